// File: rtl/mitec2_glue.sv
// Z80 bus glue: strobe/chip-select decode, two-bank DRAM RAS/MUX/CAS
// sequencing with RAS-only refresh, 8-bit refresh row extension and NMI sync.

module mitec2_bank #(
  parameter int CAS_DLY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ras_req,
  input  logic go,
  input  logic mux_on,
  output logic ras_n,
  output logic cas_n
);
  logic [CAS_DLY-1:0] cas_sr;
  logic [CAS_DLY:0]   vld_pipe;

  assign vld_pipe = {cas_sr, go & mux_on};

  // Delay line only advances while the access is live, so a dropped
  // MREQ wipes it on the next edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) cas_sr <= '0;
    else     cas_sr <= go ? vld_pipe[CAS_DLY-1:0] : '0;

  assign ras_n = ~ras_req | rst;
  assign cas_n = ~(go & vld_pipe[CAS_DLY]) | rst;
endmodule

module mitec2_glue #(
  parameter int MUX_DLY = 1,
  parameter int CAS_DLY = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic NMIN,
  input  logic RD,
  input  logic WR,
  input  logic MREQ,
  input  logic IORQ,
  input  logic RFSH,
  input  logic A6,
  input  logic A7,
  input  logic A14,
  input  logic A15,
  output logic NMI,
  output logic IOR,
  output logic IOW,
  output logic MEMR,
  output logic MEMW,
  output logic CSR,
  output logic CSW,
  output logic CE89,
  output logic CSSRAM,
  output logic CEROM2,
  output logic RAS1,
  output logic CAS1,
  output logic RAS2,
  output logic CAS2,
  output logic MUX,
  output logic RAMA7
);
  localparam int NUM_BANKS = 2;

  typedef struct packed {
    logic rd;
    logic wr;
    logic mreq;
    logic iorq;
    logic rfsh;
  } z80_req_t;

  z80_req_t bus;
  logic ior_n, iow_n, memr_n, memw_n;
  logic acc, trig, mux_on;
  logic [MUX_DLY-1:0]   mux_sr;
  logic [MUX_DLY:0]     mux_pipe;
  logic [NUM_BANKS-1:0] bank_sel, ras_n, cas_n;
  logic rfsh_q, a6_cur, a6_prev, r7;
  logic [1:0] nmi_s;

  assign bus = '{rd: ~RD, wr: ~WR, mreq: ~MREQ, iorq: ~IORQ, rfsh: ~RFSH};

  assign ior_n  = IORQ | RD;
  assign iow_n  = IORQ | WR;
  assign memr_n = MREQ | RD | ~RFSH;
  assign memw_n = MREQ | WR | ~RFSH;

  assign IOR    = ior_n | RST;
  assign IOW    = iow_n | RST;
  assign MEMR   = memr_n | RST;
  assign MEMW   = memw_n | RST;
  assign CSR    = ~(~ior_n & A7 & ~A6) | RST;
  assign CSW    = ~(~iow_n & A7 & A6) | RST;
  assign CE89   = ~(bus.mreq & ~bus.rfsh & A15 & ~A14) | RST;
  assign CEROM2 = ~(~memr_n & A15 & A14) | RST;
  assign CSSRAM = ~(~memw_n & A15 & A14) | RST;

  // MUX runs for refresh as well as for real accesses.
  assign acc      = bus.mreq & (bus.rd | bus.wr);
  assign trig     = bus.rfsh | acc;
  assign mux_pipe = {mux_sr, trig};
  assign mux_on   = trig & mux_pipe[MUX_DLY];
  assign MUX      = ~mux_on | RST;

  always_ff @(posedge CLK or posedge RST)
    if (RST) mux_sr <= '0;
    else     mux_sr <= trig ? mux_pipe[MUX_DLY-1:0] : '0;

  assign bank_sel[0] = ~A15 & ~A14;
  assign bank_sel[1] = ~A15 &  A14;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mitec2_bank #(.CAS_DLY(CAS_DLY)) u_bank (
      .clk     (CLK),
      .rst     (RST),
      .ras_req (bus.mreq & (bus.rfsh | bank_sel[b])),
      .go      (acc & ~bus.rfsh & bank_sel[b]),
      .mux_on  (mux_on),
      .ras_n   (ras_n[b]),
      .cas_n   (cas_n[b])
    );
  end

  assign RAS1 = ras_n[0];
  assign CAS1 = cas_n[0];
  assign RAS2 = ras_n[1];
  assign CAS2 = cas_n[1];

  // R7 flips when the Z80's 7-bit refresh counter wraps (A6 1 -> 0).
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rfsh_q  <= 1'b0;
      a6_cur  <= 1'b0;
      a6_prev <= 1'b0;
      r7      <= 1'b0;
    end else begin
      rfsh_q <= bus.rfsh;
      if (bus.rfsh) a6_cur <= A6;
      if (rfsh_q && !bus.rfsh) begin
        a6_prev <= a6_cur;
        if (!a6_cur && a6_prev) r7 <= ~r7;
      end
    end

  assign RAMA7 = ~RST & (bus.rfsh ? r7 : A7);

  always_ff @(posedge CLK or posedge RST)
    if (RST) nmi_s <= 2'b11;
    else     nmi_s <= {nmi_s[0], NMIN};

  assign NMI = nmi_s[1];
endmodule

// File: tb/tb_mitec2_glue.sv
// Scoreboarded bench for mitec2_glue: inputs change on the falling edge,
// outputs are sampled 1 time unit later.

module tb_mitec2_glue;
  logic CLK = 1'b0;
  logic RST, NMIN, RD, WR, MREQ, IORQ, RFSH, A6, A7, A14, A15;
  logic NMI, IOR, IOW, MEMR, MEMW, CSR, CSW, CE89, CSSRAM, CEROM2;
  logic RAS1, CAS1, RAS2, CAS2, MUX, RAMA7;

  // stimulus {RST,NMIN,RD,WR,MREQ,IORQ,RFSH,A6,A7,A14,A15}
  localparam logic [10:0] I = 11'h3F0;
  // outputs {NMI,IOR,IOW,MEMR,MEMW,CSR,CSW,CE89,CSSRAM,CEROM2,RAS1,CAS1,RAS2,CAS2,MUX,RAMA7}
  logic [15:0] outs;
  logic [15:0] exp_q[$];
  logic [15:0] obs, e;
  int n_chk = 0;
  int n_fail = 0;

  always #25 CLK = ~CLK;

  mitec2_glue #(.MUX_DLY(1), .CAS_DLY(1)) dut (
    .CLK(CLK), .RST(RST), .NMIN(NMIN), .RD(RD), .WR(WR), .MREQ(MREQ),
    .IORQ(IORQ), .RFSH(RFSH), .A6(A6), .A7(A7), .A14(A14), .A15(A15),
    .NMI(NMI), .IOR(IOR), .IOW(IOW), .MEMR(MEMR), .MEMW(MEMW), .CSR(CSR),
    .CSW(CSW), .CE89(CE89), .CSSRAM(CSSRAM), .CEROM2(CEROM2), .RAS1(RAS1),
    .CAS1(CAS1), .RAS2(RAS2), .CAS2(CAS2), .MUX(MUX), .RAMA7(RAMA7)
  );

  assign outs = {NMI, IOR, IOW, MEMR, MEMW, CSR, CSW, CE89, CSSRAM, CEROM2,
                 RAS1, CAS1, RAS2, CAS2, MUX, RAMA7};

  task automatic drive(input logic [10:0] v);
    {RST, NMIN, RD, WR, MREQ, IORQ, RFSH, A6, A7, A14, A15} = v;
  endtask

  task automatic test_reset();
    logic [10:0] stim [0:4] = '{11'h7FF, 11'h6AF, I, I, I};
    logic [15:0] expv [0:4] = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); drive(stim[k]); exp_q.push_back(expv[k]); #1;
      obs = outs; e = exp_q.pop_front(); n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL reset step%0d: got %h expected %h", k, obs, e);
      end
    end
  endtask

  task automatic test_refresh();
    logic [10:0] stim [0:5] = '{11'h3E4, 11'h3E4, 11'h3F4, 11'h3A4, 11'h3A4, 11'h3F4};
    logic [15:0] expv [0:5] = '{16'hFFFE, 16'hFFFC, 16'hFFFF, 16'hFFD6, 16'hFFD4, 16'hFFFF};
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK); drive(stim[k]); exp_q.push_back(expv[k]); #1;
      obs = outs; e = exp_q.pop_front(); n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL refresh step%0d: got %h expected %h", k, obs, e);
      end
    end
  endtask

  task automatic test_dram_read();
    logic [10:0] stim [0:9] = '{11'h3B0, 11'h2B0, 11'h2B0, 11'h2B0, 11'h2B0,
                                I, I, 11'h2B0, 11'h2B0, I};
    logic [15:0] expv [0:9] = '{16'hFFDE, 16'hEFDE, 16'hEFDC, 16'hEFCC, 16'hEFCC,
                                16'hFFFE, 16'hFFFE, 16'hEFDE, 16'hEFDC, 16'hFFFE};
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); drive(stim[k]); exp_q.push_back(expv[k]); #1;
      obs = outs; e = exp_q.pop_front(); n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL dram_read step%0d: got %h expected %h", k, obs, e);
      end
    end
  endtask

  task automatic test_dram_write();
    logic [10:0] stim [0:5] = '{11'h3B2, 11'h332, 11'h332, 11'h332, 11'h332, 11'h3F2};
    logic [15:0] expv [0:5] = '{16'hFFF6, 16'hF7F6, 16'hF7F4, 16'hF7F0, 16'hF7F0, 16'hFFFE};
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK); drive(stim[k]); exp_q.push_back(expv[k]); #1;
      obs = outs; e = exp_q.pop_front(); n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL dram_write step%0d: got %h expected %h", k, obs, e);
      end
    end
  endtask

  task automatic test_decodes();
    logic [10:0] stim [0:15] = '{11'h2B3, I, 11'h333, I, 11'h3B1, I, 11'h2D4, I,
                                 11'h35C, I, 11'h2DC, I, 11'h2D8, I, 11'h295, I};
    logic [15:0] expv [0:15] = '{16'hEFBE, 16'hFFFE, 16'hF77E, 16'hFFFE,
                                 16'hFEFE, 16'hFFFE, 16'hBBFF, 16'hFFFE,
                                 16'hDDFF, 16'hFFFE, 16'hBFFF, 16'hFFFE,
                                 16'hBFFE, 16'hFFFE, 16'hAAFF, 16'hFFFE};
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK); drive(stim[k]); exp_q.push_back(expv[k]); #1;
      obs = outs; e = exp_q.pop_front(); n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL decode step%0d: got %h expected %h", k, obs, e);
      end
    end
  endtask

  task automatic test_nmi();
    logic [10:0] stim [0:5] = '{11'h1F0, 11'h1F0, 11'h1F0, I, I, I};
    logic [15:0] expv [0:5] = '{16'hFFFE, 16'hFFFE, 16'h7FFE, 16'h7FFE, 16'h7FFE, 16'hFFFE};
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK); drive(stim[k]); exp_q.push_back(expv[k]); #1;
      obs = outs; e = exp_q.pop_front(); n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL nmi step%0d: got %h expected %h", k, obs, e);
      end
    end
  endtask

  // Refresh rows 32..159: A6 goes 0 -> 1 -> 0; R7 must read 1 only after row 128 ends.
  task automatic test_rama7();
    logic [10:0] s;
    for (int i = 32; i < 160; i++) begin
      s = 11'h3A4 | (((i >> 6) & 1) != 0 ? 11'h008 : 11'h000);
      @(negedge CLK); drive(s); exp_q.push_back(16'hFFD6 | ((i > 128) ? 16'h1 : 16'h0)); #1;
      obs = outs; e = exp_q.pop_front(); n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL rama7 row%0d: got %h expected %h", i, obs, e);
      end
      @(negedge CLK); drive(11'h3F4); exp_q.push_back(16'hFFFF); #1;
      obs = outs; e = exp_q.pop_front(); n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL rama7_idle row%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] stim [0:6] = '{11'h2B0, 11'h2B0, 11'h2B0, 11'h6B0, I, 11'h3A4, I};
    logic [15:0] expv [0:6] = '{16'hEFDE, 16'hEFDC, 16'hEFCC, 16'hFFFE, 16'hFFFE,
                                16'hFFD6, 16'hFFFE};
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK); drive(stim[k]); exp_q.push_back(expv[k]); #1;
      obs = outs; e = exp_q.pop_front(); n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL reset_mid step%0d: got %h expected %h", k, obs, e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    drive(11'h7FF);
    test_reset();
    test_refresh();
    test_dram_read();
    test_dram_write();
    test_decodes();
    test_nmi();
    test_rama7();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
